instr_fetch_queue: RTL and testbench

Decoupling queue between the instruction cache output stage and the decoder. Accepts 64-bit fetch packets (two 32-bit instructions) with PC, exception and BTB metadata, stores them in a DEPTH-entry FIFO, and presents the head packet to decode with per-slot valid bits. Masks out the slot before an odd-aligned entry PC and the slot after a predicted-taken branch in slot 0. Its `ifq_busy_o` drives the cache's `dec_busy_i`.

---
 rtl/instr_fetch_queue.sv | 212 +++++++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: decoupling FIFO between the instruction cache output
// stage and the decoder. Each entry holds one 64-bit fetch packet (two
// instruction slots) with its PC, exception and BTB metadata plus a per-slot
// valid mask computed when the packet is written. The head entry is presented
// to decode first-word-fall-through; ifq_busy_o back-pressures the cache.
//
// Optional feature: define IFQ_BYPASS_EN to let a packet arriving at an empty
// queue appear on the dq_* outputs in the same cycle. Without it there is no
// combinational path from the ifq_* inputs to the dq_* outputs.
module instr_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        core_clock_i,
    input  logic        core_reset_i,
    input  logic        core_flush_i,
    input  logic        ifq_vld_i,
    input  logic [63:0] ifq_instruction_i,
    input  logic [29:0] ifq_vpc_i,
    input  logic [3:0]  ifq_excp_code_i,
    input  logic        ifq_excp_vld_i,
    input  logic        ifq_btb_vld_i,
    input  logic        ifq_btb_index_i,
    input  logic        ifq_btb_way_i,
    input  logic [1:0]  ifq_btb_btype_i,
    input  logic [1:0]  ifq_btb_bm_pred_i,
    input  logic [29:0] ifq_btb_target_i,
    output logic        ifq_busy_o,
    output logic        dq_vld_o,
    output logic [63:0] dq_instruction_o,
    output logic [1:0]  dq_slot_vld_o,
    output logic [29:0] dq_pc0_o,
    output logic [29:0] dq_pc1_o,
    output logic [3:0]  dq_excp_code_o,
    output logic        dq_excp_vld_o,
    output logic        dq_btb_vld_o,
    output logic        dq_btb_index_o,
    output logic        dq_btb_way_o,
    output logic [1:0]  dq_btb_btype_o,
    output logic [1:0]  dq_btb_bm_pred_o,
    output logic [29:0] dq_btb_target_o,
    input  logic        dq_busy_i
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    // Only vpc[29:1] is kept: both slot PCs are rebuilt from it, and the
    // effect of vpc[0] is already captured in the stored slot mask.
    typedef struct packed {
        logic [63:0] instruction;
        logic [28:0] vpc_hi;
        logic [3:0]  excp_code;
        logic        excp_vld;
        logic        btb_vld;
        logic        btb_index;
        logic        btb_way;
        logic [1:0]  btb_btype;
        logic [1:0]  btb_bm_pred;
        logic [29:0] btb_target;
        logic [1:0]  slot_vld;
    } entry_t;

    // Slot 0 is dropped when the fetch starts on an odd word; slot 1 is
    // dropped when slot 0 of an even-aligned fetch holds a predicted-taken
    // branch. Unconditional branch types are always taken; conditional ones
    // follow the bimodal counter MSB.
    function automatic logic [1:0] calc_slot_vld(
        input logic       vpc0,
        input logic       btb_vld,
        input logic       btb_index,
        input logic [1:0] btype,
        input logic [1:0] bm_pred
    );
        logic taken;
        taken            = btb_vld & ((btype != 2'b00) | bm_pred[1]);
        calc_slot_vld[0] = ~vpc0;
        calc_slot_vld[1] = ~(taken & ~btb_index & ~vpc0);
    endfunction

    entry_t         mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;

    entry_t         in_entry_s;
    entry_t         head_s;
    logic           empty_s;
    logic           full_s;
    logic           bypass_s;
    logic           push_s;
    logic           pop_s;
    logic           head_vld_s;

    assign empty_s = (count_r == {CW{1'b0}});
    assign full_s  = (count_r == CW'(DEPTH));

    // Pack the incoming packet and compute its slot mask.
    always_comb begin
        in_entry_s             = '0;
        in_entry_s.instruction = ifq_instruction_i;
        in_entry_s.vpc_hi      = ifq_vpc_i[29:1];
        in_entry_s.excp_code   = ifq_excp_code_i;
        in_entry_s.excp_vld    = ifq_excp_vld_i;
        in_entry_s.btb_vld     = ifq_btb_vld_i;
        in_entry_s.btb_index   = ifq_btb_index_i;
        in_entry_s.btb_way     = ifq_btb_way_i;
        in_entry_s.btb_btype   = ifq_btb_btype_i;
        in_entry_s.btb_bm_pred = ifq_btb_bm_pred_i;
        in_entry_s.btb_target  = ifq_btb_target_i;
        in_entry_s.slot_vld    = calc_slot_vld(ifq_vpc_i[0], ifq_btb_vld_i,
                                               ifq_btb_index_i, ifq_btb_btype_i,
                                               ifq_btb_bm_pred_i);
    end

`ifdef IFQ_BYPASS_EN
    assign bypass_s = empty_s & ifq_vld_i & ~core_flush_i;
`else
    assign bypass_s = 1'b0;
`endif

    // A bypassed packet that decode takes immediately never touches storage.
    assign push_s     = ifq_vld_i & ~full_s & ~(bypass_s & ~dq_busy_i);
    assign pop_s      = ~empty_s & ~dq_busy_i;
    assign head_vld_s = ~empty_s | bypass_s;

    // Select the packet shown to decode: the input during bypass, else the head.
    always_comb begin
        if (bypass_s) begin
            head_s = in_entry_s;
        end else begin
            head_s = mem_r[rd_ptr_r];
        end
    end

    // Pointer and occupancy tracking; flush wins over push and pop.
    always_ff @(posedge core_clock_i or posedge core_reset_i) begin
        if (core_reset_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (core_flush_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; cleared on reset, written on an accepted push.
    always_ff @(posedge core_clock_i or posedge core_reset_i) begin
        if (core_reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s && !core_flush_i) begin
            mem_r[wr_ptr_r] <= in_entry_s;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    assign ifq_busy_o = full_s;
    assign dq_vld_o   = head_vld_s;

    // Drive decode outputs from the selected packet, zero while nothing is valid.
    always_comb begin
        dq_instruction_o = 64'd0;
        dq_slot_vld_o    = 2'b00;
        dq_pc0_o         = 30'd0;
        dq_pc1_o         = 30'd0;
        dq_excp_code_o   = 4'd0;
        dq_excp_vld_o    = 1'b0;
        dq_btb_vld_o     = 1'b0;
        dq_btb_index_o   = 1'b0;
        dq_btb_way_o     = 1'b0;
        dq_btb_btype_o   = 2'b00;
        dq_btb_bm_pred_o = 2'b00;
        dq_btb_target_o  = 30'd0;
        if (head_vld_s) begin
            dq_instruction_o = head_s.instruction;
            dq_slot_vld_o    = head_s.slot_vld;
            dq_pc0_o         = {head_s.vpc_hi, 1'b0};
            dq_pc1_o         = {head_s.vpc_hi, 1'b1};
            dq_excp_code_o   = head_s.excp_code;
            dq_excp_vld_o    = head_s.excp_vld;
            dq_btb_vld_o     = head_s.btb_vld;
            dq_btb_index_o   = head_s.btb_index;
            dq_btb_way_o     = head_s.btb_way;
            dq_btb_btype_o   = head_s.btb_btype;
            dq_btb_bm_pred_o = head_s.btb_bm_pred;
            dq_btb_target_o  = head_s.btb_target;
        end else begin
            dq_instruction_o = 64'd0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed testbench for instr_fetch_queue (default build, DEPTH = 4).
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        vld;
    logic [63:0] instr;
    logic [29:0] vpc;
    logic [3:0]  excp_code;
    logic        excp_vld;
    logic        btb_vld;
    logic        btb_index;
    logic        btb_way;
    logic [1:0]  btb_btype;
    logic [1:0]  btb_bm_pred;
    logic [29:0] btb_target;
    logic        busy;
    logic        dq_vld;
    logic [63:0] dq_instr;
    logic [1:0]  dq_slot;
    logic [29:0] dq_pc0;
    logic [29:0] dq_pc1;
    logic [3:0]  dq_excp_code;
    logic        dq_excp_vld;
    logic        dq_btb_vld;
    logic        dq_btb_index;
    logic        dq_btb_way;
    logic [1:0]  dq_btb_btype;
    logic [1:0]  dq_btb_bm_pred;
    logic [29:0] dq_btb_target;
    logic        dq_busy;

    int checks = 0;
    int errors = 0;

    instr_fetch_queue #(.DEPTH(4)) dut (
        .core_clock_i      (clk),
        .core_reset_i      (rst),
        .core_flush_i      (flush),
        .ifq_vld_i         (vld),
        .ifq_instruction_i (instr),
        .ifq_vpc_i         (vpc),
        .ifq_excp_code_i   (excp_code),
        .ifq_excp_vld_i    (excp_vld),
        .ifq_btb_vld_i     (btb_vld),
        .ifq_btb_index_i   (btb_index),
        .ifq_btb_way_i     (btb_way),
        .ifq_btb_btype_i   (btb_btype),
        .ifq_btb_bm_pred_i (btb_bm_pred),
        .ifq_btb_target_i  (btb_target),
        .ifq_busy_o        (busy),
        .dq_vld_o          (dq_vld),
        .dq_instruction_o  (dq_instr),
        .dq_slot_vld_o     (dq_slot),
        .dq_pc0_o          (dq_pc0),
        .dq_pc1_o          (dq_pc1),
        .dq_excp_code_o    (dq_excp_code),
        .dq_excp_vld_o     (dq_excp_vld),
        .dq_btb_vld_o      (dq_btb_vld),
        .dq_btb_index_o    (dq_btb_index),
        .dq_btb_way_o      (dq_btb_way),
        .dq_btb_btype_o    (dq_btb_btype),
        .dq_btb_bm_pred_o  (dq_btb_bm_pred),
        .dq_btb_target_o   (dq_btb_target),
        .dq_busy_i         (dq_busy)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a run that never finishes.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input logic [29:0] pc, input logic bv, input logic bi,
                           input logic [1:0] bt, input logic [1:0] bp);
        vpc         = pc;
        instr       = {2'b10, pc, 2'b01, pc};
        btb_vld     = bv;
        btb_index   = bi;
        btb_way     = bv;
        btb_btype   = bt;
        btb_bm_pred = bp;
        btb_target  = pc + 30'h40;
        excp_vld    = 1'b0;
        excp_code   = 4'd0;
    endtask

    // Present one packet for a single cycle (decoder held busy by caller).
    task automatic send(input logic [29:0] pc, input logic bv, input logic bi,
                        input logic [1:0] bt, input logic [1:0] bp);
        set_pkt(pc, bv, bi, bt, bp);
        vld = 1'b1;
        tick();
        vld = 1'b0;
    endtask

    task automatic pop_one();
        dq_busy = 1'b0;
        tick();
        dq_busy = 1'b1;
    endtask

    task automatic check_head_pc(input string tag, input logic [29:0] pc0);
        check_eq({tag, "_vld"}, {63'd0, dq_vld}, 64'd1);
        check_eq({tag, "_pc0"}, {34'd0, dq_pc0}, {34'd0, pc0});
        check_eq({tag, "_instr"}, dq_instr, {2'b10, pc0, 2'b01, pc0});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; vld = 1'b0; dq_busy = 1'b1;
        set_pkt(30'd0, 1'b0, 1'b0, 2'b00, 2'b00);
        #2;
        // Reset state
        check_eq("rst_vld",  {63'd0, dq_vld}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_pc1",  {34'd0, dq_pc1}, 64'd0);
        check_eq("rst_slot", {62'd0, dq_slot}, 64'd0);
        check_eq("rst_instr", dq_instr, 64'd0);
        tick(); tick();
        rst = 1'b0;

        // Plain aligned packet, no prediction; no same-cycle visibility
        set_pkt(30'h100, 1'b0, 1'b0, 2'b00, 2'b00);
        vld = 1'b1;
        #1;
        check_eq("nobypass_vld", {63'd0, dq_vld}, 64'd0);
        tick();
        vld = 1'b0;
        check_head_pc("p100", 30'h100);
        check_eq("p100_pc1",  {34'd0, dq_pc1}, 64'h101);
        check_eq("p100_slot", {62'd0, dq_slot}, 64'd3);
        pop_one();
        check_eq("p100_popped", {63'd0, dq_vld}, 64'd0);

        // Odd-aligned fetch drops slot 0
        send(30'h101, 1'b0, 1'b0, 2'b00, 2'b00);
        check_eq("p101_slot", {62'd0, dq_slot}, 64'd2);
        check_eq("p101_pc0",  {34'd0, dq_pc0}, 64'h100);
        check_eq("p101_pc1",  {34'd0, dq_pc1}, 64'h101);
        pop_one();

        // Taken conditional branch in slot 0 drops slot 1
        send(30'h100, 1'b1, 1'b0, 2'b00, 2'b10);
        check_eq("taken_slot", {62'd0, dq_slot}, 64'd1);
        check_eq("taken_btbv", {63'd0, dq_btb_vld}, 64'd1);
        check_eq("taken_tgt",  {34'd0, dq_btb_target}, 64'h140);
        check_eq("taken_bp",   {62'd0, dq_btb_bm_pred}, 64'd2);
        pop_one();

        // Weakly not-taken conditional keeps both slots
        send(30'h100, 1'b1, 1'b0, 2'b00, 2'b01);
        check_eq("nottaken_slot", {62'd0, dq_slot}, 64'd3);
        pop_one();

        // Jump in slot 1 keeps both slots
        send(30'h200, 1'b1, 1'b1, 2'b10, 2'b00);
        check_eq("jmp_slot1_slot", {62'd0, dq_slot}, 64'd3);
        check_eq("jmp_slot1_bt",   {62'd0, dq_btb_btype}, 64'd2);
        pop_one();

        // Indirect on odd fetch: slot 0 gone, slot 1 kept
        send(30'h203, 1'b1, 1'b0, 2'b01, 2'b00);
        check_eq("ind_odd_slot", {62'd0, dq_slot}, 64'd2);
        pop_one();

        // Fill to full with decoder stalled
        send(30'h10, 1'b0, 1'b0, 2'b00, 2'b00);
        send(30'h12, 1'b0, 1'b0, 2'b00, 2'b00);
        send(30'h14, 1'b0, 1'b0, 2'b00, 2'b00);
        check_eq("three_busy", {63'd0, busy}, 64'd0);
        send(30'h16, 1'b0, 1'b0, 2'b00, 2'b00);
        check_eq("full_busy", {63'd0, busy}, 64'd1);
        // Fifth packet offered while full is held off, head stays put
        set_pkt(30'h18, 1'b0, 1'b0, 2'b00, 2'b00);
        vld = 1'b1;
        tick();
        check_eq("held_busy", {63'd0, busy}, 64'd1);
        check_head_pc("held_head", 30'h10);
        // One pop: no push that edge, busy drops
        pop_one();
        check_eq("after_pop_busy", {63'd0, busy}, 64'd0);
        check_head_pc("after_pop_head", 30'h12);
        // Held packet now accepted into the wrapped slot
        tick();
        vld = 1'b0;
        check_eq("refill_busy", {63'd0, busy}, 64'd1);
        pop_one();
        check_head_pc("drain_14", 30'h14);
        pop_one();
        check_head_pc("drain_16", 30'h16);
        pop_one();
        check_head_pc("drain_18", 30'h18);
        pop_one();
        check_eq("drained_vld", {63'd0, dq_vld}, 64'd0);

        // Simultaneous push and pop with one entry keeps count at one
        send(30'h20, 1'b0, 1'b0, 2'b00, 2'b00);
        set_pkt(30'h22, 1'b0, 1'b0, 2'b00, 2'b00);
        vld = 1'b1;
        dq_busy = 1'b0;
        tick();
        vld = 1'b0;
        dq_busy = 1'b1;
        check_head_pc("pushpop_head", 30'h22);
        pop_one();
        check_eq("pushpop_empty", {63'd0, dq_vld}, 64'd0);

        // Flush with three queued and a packet offered in the same cycle
        send(30'h30, 1'b0, 1'b0, 2'b00, 2'b00);
        send(30'h32, 1'b0, 1'b0, 2'b00, 2'b00);
        send(30'h34, 1'b0, 1'b0, 2'b00, 2'b00);
        set_pkt(30'h36, 1'b0, 1'b0, 2'b00, 2'b00);
        vld = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vld = 1'b0;
        check_eq("flush_vld",  {63'd0, dq_vld}, 64'd0);
        check_eq("flush_busy", {63'd0, busy}, 64'd0);
        tick();
        check_eq("flush_dropped", {63'd0, dq_vld}, 64'd0);
        send(30'h40, 1'b0, 1'b0, 2'b00, 2'b00);
        check_head_pc("post_flush", 30'h40);
        pop_one();

        // Exception packet keeps its mask and exception fields
        set_pkt(30'h51, 1'b0, 1'b0, 2'b00, 2'b00);
        excp_vld  = 1'b1;
        excp_code = 4'd1;
        vld = 1'b1;
        tick();
        vld = 1'b0;
        excp_vld = 1'b0;
        excp_code = 4'd0;
        check_eq("excp_vld",  {63'd0, dq_excp_vld}, 64'd1);
        check_eq("excp_code", {60'd0, dq_excp_code}, 64'd1);
        check_eq("excp_slot", {62'd0, dq_slot}, 64'd2);
        send(30'h60, 1'b0, 1'b0, 2'b00, 2'b00);

        // Asynchronous reset in mid-cycle clears outputs immediately
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_vld",   {63'd0, dq_vld}, 64'd0);
        check_eq("arst_instr", dq_instr, 64'd0);
        check_eq("arst_pc1",   {34'd0, dq_pc1}, 64'd0);
        check_eq("arst_excp",  {63'd0, dq_excp_vld}, 64'd0);
        check_eq("arst_busy",  {63'd0, busy}, 64'd0);
        #1;
        rst = 1'b0;
        // First push after reset release is accepted on the next edge
        send(30'h70, 1'b0, 1'b0, 2'b00, 2'b00);
        check_head_pc("post_rst", 30'h70);
        check_eq("post_rst_slot", {62'd0, dq_slot}, 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
